// File: rtl/mem_bus_sched.sv
// mem_bus_sched: arbitrates icache line fills and LSB word accesses onto one byte-wide memory bus
module mem_bus_sched #(
  parameter int LINE_BYTES = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ready,
  input  logic                    clear,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_line,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [31:0]             ls_addr,
  input  logic [2:0]              ls_len,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int CW = OW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LB = CW'(LINE_BYTES);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
  state_t                  state;
  logic [SW-1:0]           starve;
  logic [CW-1:0]           cnt, len;
  logic [31:0]             base, wd;
  logic                    io;
  logic [8*LINE_BYTES-1:0] buf_q, nbuf;
  logic [OW-1:0]           bi;
  logic [CW-1:0]           ls_n;
  logic [31:0]             line_base;
  logic                    grant_ls, first_ok;
  assign ls_n      = (ls_len == 3'd1) ? CW'(1) : (ls_len == 3'd2) ? CW'(2) : CW'(4);
  assign line_base = if_addr & ~32'(LINE_BYTES - 1);
  assign grant_ls  = ls_req && !(if_req && starve == SMAX);
  assign first_ok  = ls_addr[17:16] != 2'b11 || !io_buffer_full;
  // In read states cnt counts cycles since grant, so mem_din holds byte cnt-1
  assign bi = OW'(cnt - CW'(1));
  always_comb begin
    nbuf = buf_q;
    nbuf[{bi, 3'b000} +: 8] = mem_din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      starve   <= '0;
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      wd       <= '0;
      io       <= 1'b0;
      buf_q    <= '0;
      if_done  <= 1'b0;
      if_line  <= '0;
      ls_done  <= 1'b0;
      ls_rdata <= '0;
      mem_dout <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
    end else if (ready) begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      if (clear) starve <= '0;
      case (state)
        IDLE: begin
          if (!if_req) starve <= '0;
          if (!clear && grant_ls) begin
            if (if_req) starve <= starve + SW'(1);
            base  <= ls_addr;
            len   <= ls_n;
            wd    <= ls_wdata;
            io    <= ls_addr[17:16] == 2'b11;
            buf_q <= '0;
            if (ls_wr) begin
              state <= LS_WR;
              cnt   <= first_ok ? CW'(1) : CW'(0);
              if (first_ok) begin
                mem_a    <= ls_addr;
                mem_wr   <= 1'b1;
                mem_dout <= ls_wdata[7:0];
              end
            end else begin
              state <= LS_RD;
              cnt   <= '0;
              mem_a <= ls_addr;
            end
          end else if (!clear && if_req) begin
            state  <= IF_RD;
            starve <= '0;
            base   <= line_base;
            len    <= LB;
            cnt    <= '0;
            buf_q  <= '0;
            mem_a  <= line_base;
          end
        end
        IF_RD, LS_RD: begin
          if (clear) state <= IDLE;
          else begin
            if (cnt != '0) buf_q <= nbuf;
            if (cnt == len) begin
              state <= DONE;
              if (state == IF_RD) begin
                if_line <= nbuf;
                if_done <= 1'b1;
              end else begin
                ls_rdata <= nbuf[31:0];
                ls_done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
              if (cnt + CW'(1) != len) mem_a <= base + 32'(cnt) + 32'd1;
            end
          end
        end
        LS_WR: begin
          // cnt counts bytes already put on the bus; a full uart buffer stalls I/O stores
          if (cnt == len) begin
            state   <= DONE;
            ls_done <= 1'b1;
          end else if (!io || !io_buffer_full) begin
            mem_a    <= base + 32'(cnt);
            mem_wr   <= 1'b1;
            mem_dout <= wd[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: directed tests against a queue-based transaction model of the bus scheduler
module tb_mem_bus_sched;
  localparam int LB = 16;
  localparam int SMAX = 4;
  logic clk, reset, ready, clear, if_req, ls_req, ls_wr, io_buffer_full;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [2:0] ls_len;
  logic [7:0] mem_din;
  logic if_done, ls_done, mem_wr;
  logic [8*LB-1:0] if_line;
  logic [31:0] ls_rdata, mem_a;
  logic [7:0] mem_dout;

  mem_bus_sched #(.LINE_BYTES(LB), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_line(if_line),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-only RAM: byte at address a is a[7:0], except two patched bytes
  function automatic logic [7:0] rd(input logic [31:0] a);
    return (a == 32'h2001) ? 8'hAB : (a == 32'h2002) ? 8'hCD : a[7:0];
  endfunction
  bit [39:0] wlog[$];
  always @(posedge clk)
    if (ready) begin
      if (mem_wr) wlog.push_back({mem_a, mem_dout});
      mem_din <= rd(mem_a);
    end

  // Transaction model: queues of pending bus beats per access
  int ph, starve, rleft, rlen;
  bit is_if, wio, armed;
  logic [31:0] rbase;
  logic [31:0] rq[$];
  logic [39:0] wq[$];
  logic [31:0] e_a, e_rdata;
  logic [7:0] e_do;
  logic e_wr, e_ifd, e_lsd;
  logic [127:0] e_line;
  bit dlog[$];

  task automatic start_rd(input logic [31:0] a, input int n);
    rbase = a;
    rlen = n;
    rq.delete();
    for (int i = 0; i < n; i++) rq.push_back(a + 32'(i));
    rleft = n + 1;
    ph = 1;
    e_a = rq.pop_front();
  endtask
  task automatic issue_wr();
    if (!(wio && io_buffer_full)) begin
      {e_a, e_do} = wq.pop_front();
      e_wr = 1;
    end
  endtask
  task automatic model_step();
    logic [127:0] line;
    int n;
    e_a = 0; e_wr = 0; e_do = 0; e_ifd = 0; e_lsd = 0;
    if (clear) starve = 0;
    case (ph)
      0: begin
        if (!if_req) starve = 0;
        if (!clear && ls_req && !(if_req && starve == SMAX)) begin
          if (if_req && starve < SMAX) starve++;
          n = (ls_len == 1) ? 1 : (ls_len == 2) ? 2 : 4;
          if (ls_wr) begin
            wio = ls_addr[17:16] == 2'b11;
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back({ls_addr + 32'(i), ls_wdata[8*i +: 8]});
            ph = 2;
            issue_wr();
          end else begin
            is_if = 0;
            start_rd(ls_addr, n);
          end
        end else if (!clear && if_req) begin
          starve = 0;
          is_if = 1;
          start_rd(if_addr & ~32'(LB - 1), LB);
        end
      end
      1: begin
        if (clear) ph = 0;
        else begin
          rleft--;
          if (rleft == 0) begin
            ph = 3;
            line = 0;
            for (int i = 0; i < rlen; i++) line[8*i +: 8] = rd(rbase + 32'(i));
            if (is_if) begin e_line = line; e_ifd = 1; end
            else begin e_rdata = line[31:0]; e_lsd = 1; end
          end else if (rq.size() != 0) e_a = rq.pop_front();
        end
      end
      2: begin
        if (wq.size() == 0) begin ph = 3; e_lsd = 1; end
        else issue_wr();
      end
      default: ph = 0;
    endcase
  endtask

  initial begin
    armed = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("mem_a", mem_a, e_a);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_dout", mem_dout, e_do);
        chk("if_done", if_done, e_ifd);
        chk("ls_done", ls_done, e_lsd);
        chk("if_line", if_line, e_line);
        chk("ls_rdata", ls_rdata, e_rdata);
        if (if_done) dlog.push_back(1'b1);
        if (ls_done) dlog.push_back(1'b0);
      end
      if (reset) begin
        e_a = 0; e_wr = 0; e_do = 0; e_ifd = 0; e_lsd = 0; e_line = 0; e_rdata = 0;
        ph = 0; starve = 0; rq.delete(); wq.delete();
        armed = 1;
      end else if (ready) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ls_go(input bit wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
    ls_wr = wr; ls_addr = a; ls_len = len; ls_wdata = wd; ls_req = 1;
  endtask
  task automatic wait_done(input string name, input int want_k);
    int k = 0;
    do begin tick(); k++; end while (!(if_done || ls_done) && k < 200);
    if_req = 0;
    ls_req = 0;
    chk(name, k, want_k);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k, nd, n0;
    logic [4:0] pat;
    logic [39:0] exp_w[4];
    reset = 1; ready = 1; clear = 0; if_req = 0; ls_req = 0; ls_wr = 0; io_buffer_full = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_len = 1;
    tick(); tick();
    chk("reset_mem_a", mem_a, 0);
    chk("reset_done", {if_done, ls_done, mem_wr}, 0);
    reset = 0;
    tick();

    if_addr = 32'h100; if_req = 1;
    wait_done("if_latency", 18);
    chk("if_line_100", if_line, 128'h0F0E0D0C0B0A09080706050403020100);

    ls_go(0, 32'h2001, 2, 0);
    wait_done("ld2_latency", 4);
    chk("ld2_rdata", ls_rdata, 32'h0000CDAB);

    if_addr = 32'hFFFFFFF5; if_req = 1;
    wait_done("if_wrap_latency", 18);
    chk("if_line_wrap", if_line, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

    ls_go(0, 32'hFFFFFFFE, 4, 0);
    wait_done("ld_wrap_latency", 6);
    chk("ld_wrap_rdata", ls_rdata, 32'h0100FFFE);

    ls_go(0, 32'h8008, 3, 0);
    wait_done("ld_len3_latency", 6);
    chk("ld_len3_rdata", ls_rdata, 32'h0B0A0908);

    n0 = wlog.size();
    ls_go(1, 32'h30000, 4, 32'hDEADBEEF);
    k = 0;
    do begin
      tick(); k++;
      if (k == 2) io_buffer_full = 1;
      if (k == 5) io_buffer_full = 0;
    end while (!ls_done && k < 200);
    ls_req = 0;
    chk("io_st_latency", k, 8);
    chk("io_st_count", wlog.size() - n0, 4);
    exp_w = '{40'h00030000EF, 40'h00030001BE, 40'h00030002AD, 40'h00030003DE};
    for (int i = 0; i < 4; i++)
      if (n0 + i < wlog.size()) chk("io_st_byte", wlog[n0 + i], exp_w[i]);
    tick();

    n0 = dlog.size();
    ls_go(0, 32'h700, 1, 0);
    if_addr = 32'h300; if_req = 1;
    k = 0;
    do begin tick(); k++; end while (!if_done && k < 300);
    if_req = 0; ls_req = 0;
    tick();
    chk("starve_count", dlog.size() - n0, 5);
    pat = '1;
    for (int i = 0; i < 5; i++) if (n0 + i < dlog.size()) pat[4-i] = dlog[n0 + i];
    chk("starve_order", pat, 5'b00001);

    if_addr = 32'h200; if_req = 1;
    for (int i = 1; i <= 6; i++) tick();
    chk("clr_rd_byte5", mem_a, 32'h205);
    clear = 1; if_req = 0;
    tick();
    clear = 0;
    chk("clr_rd_idle", {mem_a, mem_wr}, 0);
    nd = 0;
    repeat (20) begin tick(); nd += int'(if_done); end
    chk("clr_rd_no_done", nd, 0);

    n0 = wlog.size();
    ls_go(1, 32'h4000, 4, 32'h11223344);
    k = 0;
    do begin
      tick(); k++;
      if (k == 2) clear = 1;
      if (k == 3) clear = 0;
    end while (!ls_done && k < 200);
    ls_req = 0;
    chk("clr_wr_latency", k, 5);
    chk("clr_wr_count", wlog.size() - n0, 4);
    if (n0 + 3 < wlog.size()) chk("clr_wr_last", wlog[n0 + 3], 40'h0000400311);
    tick();

    ls_go(0, 32'h9005, 1, 0);
    clear = 1;
    tick();
    clear = 0;
    k = 1;
    do begin tick(); k++; end while (!ls_done && k < 200);
    ls_req = 0;
    chk("clr_idle_latency", k, 4);
    chk("clr_idle_rdata", ls_rdata, 32'h05);
    tick();

    ls_go(0, 32'h5000, 4, 0);
    k = 0;
    do begin
      tick(); k++;
      if (k == 3) ready = 0;
      if (k == 7) ready = 1;
    end while (!ls_done && k < 200);
    ls_req = 0;
    chk("freeze_latency", k, 10);
    chk("freeze_rdata", ls_rdata, 32'h03020100);
    tick();

    ls_go(0, 32'h6004, 4, 0);
    k = 0;
    do begin
      tick(); k++;
      if (k == 2) reset = 1;
      if (k == 3) begin
        chk("rst_mid_bus", {mem_a, mem_dout, mem_wr, if_done, ls_done}, 0);
        chk("rst_mid_data", {if_line, ls_rdata}, 0);
        reset = 0;
      end
    end while (!ls_done && k < 200);
    ls_req = 0;
    chk("rst_regrant_latency", k, 9);
    chk("rst_regrant_rdata", ls_rdata, 32'h07060504);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
